// File: rtl/tb_memory_mp_if.sv
// Request/response bundle for the multi-port banked memory; one lane per port.
// Latency: none, wires only.
// Backpressure: gnt per port; a requester keeps req (and its fields) up until req&gnt.
//
// Port summary (lane p uses bit p, bits [32p+:32] or [4p+:4]):
//   req/wr/addr/wdata/byteen : requester -> memory
//   gnt                      : memory -> requester, combinational accept
//   rvalid/rdata/rerr        : memory -> requester, one-cycle response pulse
interface tb_memory_mp_if #(
  parameter int NPORT = 2
) ();

  logic [NPORT-1:0]      req;
  logic [NPORT-1:0]      wr;
  logic [32*NPORT-1:0]   addr;
  logic [32*NPORT-1:0]   wdata;
  logic [4*NPORT-1:0]    byteen;
  logic [NPORT-1:0]      gnt;
  logic [NPORT-1:0]      rvalid;
  logic [32*NPORT-1:0]   rdata;
  logic [NPORT-1:0]      rerr;

  modport master (
    output req, wr, addr, wdata, byteen,
    input  gnt, rvalid, rdata, rerr
  );

  modport slave (
    input  req, wr, addr, wdata, byteen,
    output gnt, rvalid, rdata, rerr
  );

endinterface

// File: rtl/tb_memory_mp.sv
// Multi-port, multi-bank 32-bit SRAM model with per-bank round-robin arbitration.
// Latency: RD_LATENCY cycles from accept (req&gnt) to the single-cycle rvalid pulse.
// Backpressure: gnt drops for ports losing bank arbitration; unmapped requests always accepted.
//
// Ports:
//   clk      : sole clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset (memory contents are not reset)
//   bus      : tb_memory_mp_if.slave, NPORT request/response lanes
module tb_memory_mp #(
  parameter int          NPORT      = 2,
  parameter int          NBANK      = 2,
  parameter int          BANK_DEPTH = 16384,
  parameter logic [31:0] BANK_SPAN  = 32'h10000,
  parameter int          RD_LATENCY = 1
) (
  input logic           clk,
  input logic           reset_n,
  tb_memory_mp_if.slave bus
);

  localparam int          AW       = $clog2(BANK_DEPTH);
  localparam int          BW       = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int          PW       = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [31:0] ERR_WORD = 32'hdeadbeef;

  // ---------------------------------------------------------------------------
  // Address decode per port
  // ---------------------------------------------------------------------------
  // The bank is the quotient addr/BANK_SPAN; anything at or past NBANK banks is
  // unmapped. The word index is the offset inside the bank with the byte lane
  // bits dropped.
  logic [NPORT-1:0] p_map;
  logic [BW-1:0]    p_bank [NPORT];
  logic [AW-1:0]    p_widx [NPORT];

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      p_map[p]  = (bus.addr[32*p +: 32] / BANK_SPAN) < 32'(NBANK);
      p_bank[p] = BW'(bus.addr[32*p +: 32] / BANK_SPAN);
      p_widx[p] = AW'((bus.addr[32*p +: 32] % BANK_SPAN) >> 2);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank round-robin arbitration and grant generation
  // ---------------------------------------------------------------------------
  // Each bank scans ports starting at its pointer and takes the first one
  // addressing it. Unmapped requests bypass the banks entirely. Nothing is
  // granted while reset is asserted so no access can slip into a bank.
  logic [PW-1:0]    rr_ptr   [NBANK];
  logic [PW-1:0]    bank_sel [NBANK];
  logic [NBANK-1:0] bank_acc;
  logic [NPORT-1:0] gnt_c;

  always_comb begin
    int pi;
    pi       = 0;
    gnt_c    = '0;
    bank_acc = '0;
    for (int b = 0; b < NBANK; b++) begin
      bank_sel[b] = '0;
      for (int i = 0; i < NPORT; i++) begin
        pi = int'(rr_ptr[b]) + i;
        if (pi >= NPORT) begin
          pi = pi - NPORT;
        end
        if (reset_n && !bank_acc[b] && bus.req[pi] && p_map[pi] &&
            (p_bank[pi] == BW'(b))) begin
          bank_acc[b] = 1'b1;
          bank_sel[b] = PW'(pi);
          gnt_c[pi]   = 1'b1;
        end
      end
    end
    for (int p = 0; p < NPORT; p++) begin
      if (reset_n && bus.req[p] && !p_map[p]) begin
        gnt_c[p] = 1'b1;
      end
    end
  end

  assign bus.gnt = gnt_c;

  // Pointer moves just past the winner; an idle bank keeps its pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NBANK; b++) begin
        rr_ptr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (bank_acc[b]) begin
          rr_ptr[b] <= (int'(bank_sel[b]) == NPORT - 1) ? '0 : bank_sel[b] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM banks
  // ---------------------------------------------------------------------------
  // One access per bank per cycle. The read register only loads on a read so a
  // response can still pick it up the cycle after acceptance. Neither the array
  // nor the read register is reset; response gating hides stale contents.
  logic [31:0] bank_rdata [NBANK];

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [31:0]   mem [BANK_DEPTH];
    logic [31:0]   rd_q;
    logic [AW-1:0] a_idx;
    logic          a_wr;
    logic [31:0]   a_wdat;
    logic [3:0]    a_be;

    always_comb begin
      a_idx  = p_widx[bank_sel[b]];
      a_wr   = bus.wr[bank_sel[b]];
      a_wdat = bus.wdata[32*bank_sel[b] +: 32];
      a_be   = bus.byteen[4*bank_sel[b] +: 4];
    end

    always_ff @(posedge clk) begin
      if (bank_acc[b]) begin
        if (a_wr) begin
          for (int i = 0; i < 4; i++) begin
            if (a_be[i]) begin
              mem[a_idx][8*i +: 8] <= a_wdat[8*i +: 8];
            end
          end
        end else begin
          rd_q <= mem[a_idx];
        end
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  // ---------------------------------------------------------------------------
  // Per-port response pipeline
  // ---------------------------------------------------------------------------
  // Stage 0 holds valid/err plus the write flag and bank select of the access
  // accepted last cycle; that is the only cycle the bank read register is
  // guaranteed to hold our word, so the response word is formed there and
  // then carried down the remaining stages together with valid/err.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [RD_LATENCY-1:0] v_q;
    logic [RD_LATENCY-1:0] e_q;
    logic                  w0_q;
    logic [BW-1:0]         bs0_q;
    logic [31:0]           s0_dat;
    logic [31:0]           out_dat;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q   <= '0;
        e_q   <= '0;
        w0_q  <= 1'b0;
        bs0_q <= '0;
      end else begin
        v_q[0] <= gnt_c[p];
        e_q[0] <= gnt_c[p] & ~p_map[p];
        w0_q   <= bus.wr[p];
        bs0_q  <= p_bank[p];
        for (int s = 1; s < RD_LATENCY; s++) begin
          v_q[s] <= v_q[s-1];
          e_q[s] <= e_q[s-1];
        end
      end
    end

    // Zero unless valid, so carried data is already clean for idle stages.
    always_comb begin
      s0_dat = '0;
      if (v_q[0]) begin
        if (e_q[0]) begin
          s0_dat = ERR_WORD;
        end else if (!w0_q) begin
          s0_dat = bank_rdata[bs0_q];
        end
      end
    end

    if (RD_LATENCY == 1) begin : g_nodly
      assign out_dat = s0_dat;
    end else begin : g_dly
      logic [31:0] d_q [1:RD_LATENCY-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 1; s < RD_LATENCY; s++) begin
            d_q[s] <= '0;
          end
        end else begin
          d_q[1] <= s0_dat;
          for (int s = 2; s < RD_LATENCY; s++) begin
            d_q[s] <= d_q[s-1];
          end
        end
      end

      assign out_dat = d_q[RD_LATENCY-1];
    end

    assign bus.rvalid[p]          = v_q[RD_LATENCY-1];
    assign bus.rerr[p]            = v_q[RD_LATENCY-1] & e_q[RD_LATENCY-1];
    assign bus.rdata[32*p +: 32]  = out_dat;
  end

endmodule

// File: tb/tb_tb_memory_mp.sv
// Bench for tb_memory_mp: three copies (RD_LATENCY 1, 2, 3) driven with identical stimulus.
// Latency: reference model records the response formed at each accept; copy L must show it L cycles later.
// Backpressure: model reproduces per-bank round-robin grants and checks gnt every cycle.
module tb_tb_memory_mp;

  localparam int          NP    = 2;
  localparam int          NB    = 2;
  localparam int          DEPTH = 16384;
  localparam logic [31:0] SPAN  = 32'h10000;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  tb_memory_mp_if #(.NPORT(NP)) bus1 ();
  tb_memory_mp_if #(.NPORT(NP)) bus2 ();
  tb_memory_mp_if #(.NPORT(NP)) bus3 ();

  tb_memory_mp #(.NPORT(NP), .NBANK(NB), .BANK_DEPTH(DEPTH), .BANK_SPAN(SPAN), .RD_LATENCY(1))
    u_l1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  tb_memory_mp #(.NPORT(NP), .NBANK(NB), .BANK_DEPTH(DEPTH), .BANK_SPAN(SPAN), .RD_LATENCY(2))
    u_l2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  tb_memory_mp #(.NPORT(NP), .NBANK(NB), .BANK_DEPTH(DEPTH), .BANK_SPAN(SPAN), .RD_LATENCY(3))
    u_l3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  int n_vec = 0;
  int n_err = 0;
  int tcyc  = 0;

  // Response history: what was produced by accepts in cycle t, slot t%8.
  logic [NP-1:0] hv [8];
  logic [NP-1:0] he [8];
  logic [31:0]   hd [8][NP];
  int unsigned   rr [NB];
  logic [31:0]   mm [int unsigned];

  logic [NP-1:0] obs_gnt [3];
  logic [NP-1:0] obs_rv  [3];
  logic [NP-1:0] obs_re  [3];
  logic [31:0]   obs_rd  [3][NP];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, tcyc);
    end
  endtask

  task automatic drive(input logic [NP-1:0] rq, input logic [NP-1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] be0, input logic [3:0] be1);
    bus1.req = rq; bus1.wr = w; bus1.addr = {a1, a0}; bus1.wdata = {d1, d0}; bus1.byteen = {be1, be0};
    bus2.req = rq; bus2.wr = w; bus2.addr = {a1, a0}; bus2.wdata = {d1, d0}; bus2.byteen = {be1, be0};
    bus3.req = rq; bus3.wr = w; bus3.addr = {a1, a0}; bus3.wdata = {d1, d0}; bus3.byteen = {be1, be0};
  endtask

  function automatic logic [31:0] mem_rd(input int unsigned key);
    if (mm.exists(key)) return mm[key];
    return 32'h0;
  endfunction

  // One clock cycle: check responses, apply inputs, check grants, advance model.
  task automatic cycle(input logic [NP-1:0] rq, input logic [NP-1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] be0, input logic [3:0] be1, input logic rn);
    logic [31:0]   a   [NP];
    logic [31:0]   d   [NP];
    logic [3:0]    be  [NP];
    logic [NP-1:0] g;
    logic [NP-1:0] mp;
    int unsigned   bk  [NP];
    int unsigned   key [NP];
    int            slot;
    logic [31:0]   word;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; be[0] = be0; be[1] = be1;

    @(negedge clk);
    obs_rv[0] = bus1.rvalid; obs_re[0] = bus1.rerr;
    obs_rd[0][0] = bus1.rdata[31:0]; obs_rd[0][1] = bus1.rdata[63:32];
    obs_rv[1] = bus2.rvalid; obs_re[1] = bus2.rerr;
    obs_rd[1][0] = bus2.rdata[31:0]; obs_rd[1][1] = bus2.rdata[63:32];
    obs_rv[2] = bus3.rvalid; obs_re[2] = bus3.rerr;
    obs_rd[2][0] = bus3.rdata[31:0]; obs_rd[2][1] = bus3.rdata[63:32];
    for (int k = 0; k < 3; k++) begin
      slot = (tcyc + 8 - (k + 1)) % 8;
      chk($sformatf("rvalid_L%0d", k + 1), 32'(obs_rv[k]), 32'(hv[slot]));
      chk($sformatf("rerr_L%0d", k + 1), 32'(obs_re[k]), 32'(he[slot]));
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rdata_L%0d_p%0d", k + 1, p), obs_rd[k][p], hd[slot][p]);
      end
    end

    reset_n = rn;
    drive(rq, w, a0, a1, d0, d1, be0, be1);
    #1;

    // Reference: unmapped always granted, each bank serves the first requester
    // found scanning from its round-robin pointer.
    g = '0;
    for (int p = 0; p < NP; p++) begin
      bk[p]  = a[p] / SPAN;
      mp[p]  = bk[p] < NB;
      key[p] = bk[p] * DEPTH + ((a[p] % SPAN) >> 2);
    end
    if (rn) begin
      for (int p = 0; p < NP; p++) begin
        if (rq[p] && !mp[p]) g[p] = 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        for (int i = 0; i < NP; i++) begin
          int unsigned p;
          p = (rr[b] + i) % NP;
          if (rq[p] && mp[p] && bk[p] == b) begin
            g[p]  = 1'b1;
            rr[b] = (p + 1) % NP;
            break;
          end
        end
      end
    end
    obs_gnt[0] = bus1.gnt; obs_gnt[1] = bus2.gnt; obs_gnt[2] = bus3.gnt;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("gnt_L%0d", k + 1), 32'(obs_gnt[k]), 32'(g));
    end

    slot = tcyc % 8;
    if (!rn) begin
      for (int s = 0; s < 8; s++) begin
        hv[s] = '0; he[s] = '0;
        for (int p = 0; p < NP; p++) hd[s][p] = '0;
      end
      for (int b = 0; b < NB; b++) rr[b] = 0;
    end else begin
      hv[slot] = g; he[slot] = '0;
      for (int p = 0; p < NP; p++) begin
        hd[slot][p] = '0;
        if (g[p]) begin
          if (!mp[p]) begin
            hd[slot][p] = 32'hdeadbeef;
            he[slot][p] = 1'b1;
          end else if (!w[p]) begin
            hd[slot][p] = mem_rd(key[p]);
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (g[p] && mp[p] && w[p]) begin
          word = mem_rd(key[p]);
          for (int i = 0; i < 4; i++) begin
            if (be[p][i]) word[8*i +: 8] = d[p][8*i +: 8];
          end
          mm[key[p]] = word;
        end
      end
    end
    tcyc++;
  endtask

  task automatic idle();
    cycle('0, '0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
  endtask

  // Mostly a small pool of mapped words (with random byte-lane bits), sometimes unmapped.
  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 99) < 85)
      return 32'($urandom_range(0, NB - 1)) * SPAN + 32'(4 * $urandom_range(0, 16)) + 32'($urandom_range(0, 3));
    return 32'h0002_0000 + ($urandom & 32'h7fff_fffc);
  endfunction

  initial begin
    reset_n = 1'b0;
    drive('0, '0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    for (int s = 0; s < 8; s++) begin
      hv[s] = '0; he[s] = '0;
      for (int p = 0; p < NP; p++) hd[s][p] = '0;
    end
    for (int b = 0; b < NB; b++) rr[b] = 0;

    // Reset state: requests present but nothing granted or returned.
    repeat (3) cycle(2'b11, 2'b00, 32'h0, 32'h10000, 32'h0, 32'h0, 4'hf, 4'hf, 1'b0);
    chk("rst_gnt", 32'(obs_gnt[0]), 32'h0);
    chk("rst_rvalid", 32'(obs_rv[2]), 32'h0);

    // Known contents for the address pool.
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k <= 16; k++) begin
        cycle(2'b01, 2'b01, 32'(b) * SPAN + 32'(4 * k), 32'h0, 32'h0, 32'h0, 4'hf, 4'h0, 1'b1);
      end
    end

    // Partial byte write then read back.
    cycle(2'b01, 2'b01, 32'h40, 32'h0, 32'h12345678, 32'h0, 4'b0011, 4'h0, 1'b1);
    cycle(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    chk("wr_resp_vld", 32'(obs_rv[0]), 32'h1);
    chk("wr_resp_dat", obs_rd[0][0], 32'h0);
    idle();
    chk("rd_resp_vld", 32'(obs_rv[0]), 32'h1);
    chk("rd_resp_dat", obs_rd[0][0], 32'h00005678);
    chk("rd_resp_err", 32'(obs_re[0]), 32'h0);

    // Round-robin from reset on a shared bank.
    cycle('0, '0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 2'b00, 32'h10000, 32'h10000, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
      chk($sformatf("rr_gnt%0d", i), 32'(obs_gnt[0]), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) chk($sformatf("rr_resp%0d", i), 32'(obs_rv[0]), (i % 2 == 1) ? 32'h1 : 32'h2);
    end
    idle();

    // Unmapped access.
    cycle(2'b10, 2'b00, 32'h0, 32'h30000, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    chk("unmap_gnt", 32'(obs_gnt[0]), 32'h2);
    idle();
    chk("unmap_vld", 32'(obs_rv[0]), 32'h2);
    chk("unmap_dat", obs_rd[0][1], 32'hdeadbeef);
    chk("unmap_err", 32'(obs_re[0]), 32'h2);

    // Back-to-back reads on the latency-3 copy.
    for (int i = 0; i < 3; i++)
      cycle(2'b01, 2'b01, 32'(4 * i), 32'h0, 32'ha0000000 + 32'(4 * i), 32'h0, 4'hf, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(2'b01, 2'b00, 32'(4 * i), 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("lat3_vld%0d", i), 32'(obs_rv[2]), 32'h1);
      chk($sformatf("lat3_dat%0d", i), obs_rd[2][0], 32'ha0000000 + 32'(4 * i));
    end

    // Different banks in parallel.
    cycle(2'b11, 2'b00, 32'h4, 32'h10004, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    chk("par_gnt", 32'(obs_gnt[2]), 32'h3);
    idle();
    chk("par_vld_L1", 32'(obs_rv[0]), 32'h3);
    idle();
    idle();
    chk("par_vld_L3", 32'(obs_rv[2]), 32'h3);
    chk("par_dat_L3", obs_rd[2][0], 32'ha0000004);

    // Reset pulse with a read in flight on the latency-2 copy.
    cycle(2'b01, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    cycle('0, '0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0);
    idle();
    chk("rst_flush_L2", 32'(obs_rv[1]), 32'h0);
    idle();
    chk("rst_flush_L3", 32'(obs_rv[2]), 32'h0);
    cycle(2'b01, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    idle();
    chk("mem_kept", obs_rd[0][0], 32'ha0000008);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      cycle({1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)},
            2'($urandom), rand_addr(), rand_addr(), $urandom, $urandom,
            4'($urandom), 4'($urandom), 1'($urandom_range(0, 199) != 0));
    end
    repeat (5) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tb_memory_mp.md
TB_MEMORY_MP -- requirements
Module: tb_memory_mp

Interface
REQ-001 Parameter NPORT, default 2, SHALL set the number of independent bus ports (1..4).
REQ-002 Parameter NBANK, default 2, SHALL set the number of SRAM banks (1..4).
REQ-003 Parameter BANK_DEPTH, default 16384, SHALL set the 32-bit words per bank; AW = clog2(BANK_DEPTH).
REQ-004 Parameter BANK_SPAN, default 32'h10000, SHALL set the byte span per bank; bank b maps [b*BANK_SPAN, (b+1)*BANK_SPAN-1].
REQ-005 Parameter RD_LATENCY, default 1, SHALL set the accept-to-response latency in cycles (1..4).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NPORT  per-port request.
REQ-009 wr  input  NPORT  per-port write (1) / read (0).
REQ-010 addr  input  32*NPORT  per-port byte address, port p at [32p+:32].
REQ-011 wdata  input  32*NPORT  per-port write data.
REQ-012 byteen  input  4*NPORT  per-port write byte enables.
REQ-013 gnt  output  NPORT  per-port grant; the request is accepted when req&gnt are high in one cycle.
REQ-014 rvalid  output  NPORT  per-port response valid.
REQ-015 rdata  output  32*NPORT  per-port response data.
REQ-016 rerr  output  NPORT  per-port error, qualified by rvalid.

Function
REQ-017 A port SHALL be mapped to bank b when addr < NBANK*BANK_SPAN, with b = addr/BANK_SPAN and word index addr[2+:AW] taken relative to the bank base; addr[1:0] SHALL be ignored.
REQ-018 An unmapped request SHALL be granted combinationally in the same cycle without touching any bank.
REQ-019 Each bank SHALL have a round-robin arbiter over the ports requesting it; gnt is combinational from req/addr and the arbiter pointer.
REQ-020 The arbiter pointer SHALL move to (granted port + 1) mod NPORT after a grant, and SHALL hold when the bank has no request.
REQ-021 A bank SHALL perform at most one access per cycle; an ungranted port SHALL see gnt=0 and MAY hold its req.
REQ-022 A write SHALL update only the bytes whose byteen bit is set; a read SHALL return the word as it was before any same-cycle write.
REQ-023 Accept at cycle t SHALL produce rvalid=1 on that port at cycle t+RD_LATENCY for exactly one cycle, for reads, writes and unmapped accesses alike.
REQ-024 Response data: mapped read -> word, rerr=0; mapped write -> 32'h0, rerr=0; unmapped -> 32'hdeadbeef, rerr=1.
REQ-025 rdata and rerr SHALL be 0 whenever rvalid=0.
REQ-026 Each port SHALL accept one request per cycle back-to-back, with responses in acceptance order and no bubbles added.
REQ-027 The response pipeline per port SHALL be a RD_LATENCY-deep valid/err/bank-select shift register; bank read data SHALL be carried through the remaining stages when RD_LATENCY>1.
REQ-028 Different ports hitting different banks in the same cycle SHALL all be granted.

Reset
REQ-029 While reset_n=0, gnt (state part), rvalid, rerr and rdata SHALL be 0, all arbiter pointers SHALL be port 0, and all pipelines SHALL be cleared.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight responses; memory contents SHALL NOT be reset.

Verification
REQ-031 RD_LATENCY=1: port0 writes 32'h12345678 to 0x40 with byteen=4'b0011, then reads 0x40 (old word 0) -> rvalid at t+1, rdata=32'h00005678, rerr=0.
REQ-032 Port0 and port1 both request 0x10000 for 4 cycles, starting from reset -> grants go p0, p1, p0, p1, each response is 1 cycle after its grant.
REQ-033 Port1 reads 0x30000 with NBANK=2 -> gnt same cycle, rvalid with rerr=1 and rdata=32'hdeadbeef.
REQ-034 RD_LATENCY=3: port0 issues back-to-back reads of 0x0, 0x4, 0x8 -> rvalid at t+3, t+4, t+5 with data in order.
REQ-035 Port0 on bank0 and port1 on bank1 in the same cycle -> both gnt=1, both respond at t+RD_LATENCY.
REQ-036 reset_n is pulsed low at t+1 after a read accepted at t with RD_LATENCY=2 -> no rvalid at t+2, and the previously written memory is still readable afterwards.
